// File: rtl/mode_sequencer.sv
// N-way mode controller: debounced step button, direct load, per-mode enable/clear, frame mux.
// Optional feature: define MODE_LOCK_EN to honour the lock input.
module mode_sequencer #(
  parameter int NUM_MODES  = 2,
  parameter int MODE_W     = 3,
  parameter int SEG_W      = 64,
  parameter int DEB_CYCLES = 20,
  parameter int CLR_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step_btn,
  input  logic                       mode_load,
  input  logic [MODE_W-1:0]          mode_in,
  input  logic                       lock,
  input  logic [NUM_MODES*SEG_W-1:0] seg_frames_in,
  output logic [MODE_W-1:0]          mode,
  output logic [NUM_MODES-1:0]       mode_en,
  output logic [NUM_MODES-1:0]       mode_clr,
  output logic                       mode_changed,
  output logic [SEG_W-1:0]           seg_frame_out
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   MODE_LIM  = (MODE_W + 1)'(NUM_MODES);
  localparam logic [CLR_W-1:0]  CLR_INIT  = CLR_W'(CLR_CYCLES);

  logic             sync1, sync2;
  logic             stable, rise, armed;
  logic [CNT_W-1:0] cnt;
  logic             lock_ok, load_ok, step_ok, change;
  logic [MODE_W-1:0] mode_nxt;
  logic [CLR_W-1:0] clr_cnt;
  logic             clr_on;
  logic [SEG_W-1:0] frame_sel, frame_q;

`ifdef MODE_LOCK_EN
  assign lock_ok = ~lock;
`else
  assign lock_ok = ~(lock & 1'b0);
`endif

  // Synchroniser resets high so a button held through reset cannot arm the
  // step path; arming needs the input and the stable level both seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == DEB_LAST) begin
          stable <= sync2;
          cnt    <= '0;
          rise   <= sync2 & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (!sync2 && !stable) armed <= 1'b1;
    end
  end

  // Load has priority over a coincident step; an out-of-range load is ignored.
  always_comb begin
    load_ok  = mode_load && ({1'b0, mode_in} < MODE_LIM) && lock_ok;
    step_ok  = rise && lock_ok;
    mode_nxt = mode;
    change   = 1'b0;
    if (load_ok) begin
      mode_nxt = mode_in;
      change   = (mode_in != mode);
    end else if (step_ok) begin
      mode_nxt = (mode == MODE_LAST) ? '0 : mode + 1'b1;
      change   = 1'b1;
    end
  end

  always_comb begin
    frame_sel = '0;
    mode_en   = '0;
    for (int unsigned k = 0; k < NUM_MODES; k++) begin
      if (mode == MODE_W'(k)) begin
        frame_sel  = seg_frames_in[k*SEG_W +: SEG_W];
        mode_en[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= '0;
      mode_changed <= 1'b0;
      clr_cnt      <= '0;
      frame_q      <= '0;
    end else begin
      mode         <= mode_nxt;
      mode_changed <= change;
      frame_q      <= frame_sel;
      if (change)
        clr_cnt <= CLR_INIT;
      else if (clr_cnt != '0)
        clr_cnt <= clr_cnt - 1'b1;
    end
  end

  // Clear always targets the current (newest) mode; the frame blanks while it runs.
  assign clr_on        = (clr_cnt != '0);
  assign mode_clr      = clr_on ? mode_en : '0;
  assign seg_frame_out = clr_on ? '0 : frame_q;

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Generalised N-way mode controller for the Morse encoder/decoder top level.
- Debounces a single mode-cycle button and steps through NUM_MODES modes with wrap-around.
- Accepts a direct mode load.
- Issues per-mode enable and clear pulses.
- Registers and muxes the selected mode's 8-digit segment frame to the shared seg display driver.
- Replaces the fixed 2-mode toggle and AND/OR frame mux.

Parameters:
NUM_MODES, 2, number of modes (2..8)
MODE_W, 3, width of mode index; must satisfy 2^MODE_W >= NUM_MODES
SEG_W, 64, bits per mode segment frame
DEB_CYCLES, 20, consecutive equal samples required to accept a new button level (>=2)
CLR_CYCLES, 4, length in clk cycles of the clear pulse sent to the incoming mode (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
step_btn  input  1  raw (asynchronous, bouncing) mode-cycle button, active high
mode_load  input  1  load mode_in this cycle
mode_in  input  MODE_W  mode index to load
lock  input  1  mode lock request (honoured only with MODE_LOCK_EN)
seg_frames_in  input  NUM_MODES*SEG_W  concatenated frames; mode k at bits [k*SEG_W +: SEG_W]
mode  output  MODE_W  current mode index
mode_en  output  NUM_MODES  one-hot enable of the current mode
mode_clr  output  NUM_MODES  clear pulse to the incoming mode after a change
mode_changed  output  1  one-cycle pulse on every mode change
seg_frame_out  output  SEG_W  selected frame to the display driver

Behaviour:
Reset state (all asynchronous):
- mode=0, mode_en=1 (bit 0), mode_clr=0, mode_changed=0, seg_frame_out=0.
- Debouncer holds level 0 with counter 0.
Button input path:
- step_btn passes through a 2-FF synchroniser.
- The debouncer compares the synchronised value against the stable level. The counter increments while they differ and clears to 0 when they match.
- When the counter reaches DEB_CYCLES-1 the stable level flips and the counter clears.
- Glitches shorter than DEB_CYCLES cycles are ignored.
Step and load:
- A step request is a 0->1 transition of the stable level. It lasts one cycle, 3 cycles after the raw edge plus the debounce time.
- Step: mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
- Load: if mode_load=1 and mode_in<NUM_MODES, mode <= mode_in. If mode_in>=NUM_MODES the load is ignored: no change and no pulses.
- If a load and a step occur in the same cycle, the load wins and the step is discarded.
- Loading the current mode is not a change: no pulses.
Change pulses:
- On a change in cycle t, mode, mode_en and mode_changed update at t+1.
- mode_changed is high for exactly one cycle.
- mode_clr[new] is high for cycles t+1..t+CLR_CYCLES. All other mode_clr bits stay 0.
- A further change during an active clear restarts the clear for the newest mode only.
Frame output:
- seg_frame_out <= slice of seg_frames_in selected by the registered mode.
- Latency is 1 cycle after mode updates.
- While mode_clr of the current mode is high, seg_frame_out is forced to 0 (blanking).
Reset mid-operation:
- Clears the debouncer, any clear sequence in progress, and all outputs immediately.
- A button still held on release of reset does not produce a step until it has been released and pressed again.

Optional Feature:
MODE_LOCK_EN
- Defined: while lock=1, step requests and loads are discarded, and no pulses are produced. The debouncer keeps tracking, so a press made while locked never fires after unlock.
- Undefined: the lock port is ignored and the block behaves identically to lock=0.

Test Plan:
- Reset, then one clean press (held 40 cycles) with NUM_MODES=3, DEB_CYCLES=20 -> mode 0->1 once; mode_en=3'b010; mode_changed high 1 cycle; mode_clr[1] high 4 cycles; seg_frame_out=0 during the clear, then frame 1.
- Three clean presses with NUM_MODES=3 -> mode sequence 1,2,0; on wrap, mode_en returns to 3'b001.
- Bounce: 5-cycle pulses on step_btn every 10 cycles for 200 cycles, then low -> no mode change, mode_changed never asserted.
- mode_load=1, mode_in=2 in the same cycle as a debounced step from mode 0 -> mode=2, a single mode_changed pulse; mode_in=5 with NUM_MODES=3 -> ignored.
- Assert rst midway through a mode_clr pulse while the button is held -> all outputs return to reset values at once; no step after rst release until the button is released and pressed again.
- With MODE_LOCK_EN defined: lock=1, then a press plus mode_load=1/mode_in=1 -> mode stays 0; lock=0 -> still no change until a new press.
